// File: rtl/rced_et_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rced_et_ctrl
// Description : Early-terminating stochastic Roberts-cross edge controller.
//               Drives correlated SNG bits to an external RCED, counts its
//               ones and stops as soon as the threshold is met or unreachable.
// Revision    : 1.0 - initial release
// ============================================================================
module rced_et_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0][WIDTH-1:0] Bxs,
    input  logic [WIDTH:0]        thresh,
    output logic [3:0]            x,
    output logic                  c,
    input  logic                  z,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  edge_det,
    output logic [WIDTH:0]        ones_cnt,
    output logic [WIDTH:0]        cycles,
    output logic                  early
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Stream length L = 2^WIDTH, one bit wider than the counters so L - e never wraps.
    localparam logic [WIDTH+1:0] C_LEN = {2'b01, {WIDTH{1'b0}}};

    logic [1:0]            r_state;
    logic [3:0][WIDTH-1:0] r_bx;
    logic [WIDTH:0]        r_thresh;
    logic [WIDTH-1:0]      r_cnt;
    logic [WIDTH:0]        r_ones;
    logic [WIDTH:0]        r_cycles;
    logic                  r_edge;
    logic                  r_early;

    logic                  w_run;
    logic [WIDTH:0]        w_cnt_next;
    logic [WIDTH:0]        w_e;
    logic [WIDTH+1:0]      w_reach;
    logic                  w_hit;
    logic                  w_miss;
    logic                  w_early;

    assign w_run      = (r_state == S_RUN);
    assign w_cnt_next = r_ones + {{WIDTH{1'b0}}, z};
    assign w_e        = r_cycles + {{WIDTH{1'b0}}, 1'b1};
    // Best case still achievable: every remaining cycle would produce a one.
    assign w_reach    = {1'b0, w_cnt_next} + (C_LEN - {1'b0, w_e});
    assign w_hit      = (w_cnt_next >= r_thresh);
    assign w_miss     = (w_reach < {1'b0, r_thresh});
    assign w_early    = ({1'b0, w_e} < C_LEN);

    for (genvar i = 0; i < 4; i++) begin : g_sng
        assign x[i] = w_run && (r_cnt < r_bx[i]);
    end

    assign c         = w_run & r_cnt[0];
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign edge_det  = r_edge;
    assign ones_cnt  = r_ones;
    assign cycles    = r_cycles;
    assign early     = r_early;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_bx     <= '0;
            r_thresh <= '0;
            r_cnt    <= '0;
            r_ones   <= '0;
            r_cycles <= '0;
            r_edge   <= 1'b0;
            r_early  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_bx     <= Bxs;
                        r_thresh <= thresh;
                        r_cnt    <= '0;
                        r_ones   <= '0;
                        r_cycles <= '0;
                        r_edge   <= 1'b0;
                        r_early  <= 1'b0;
                        if (thresh == '0) begin
                            r_state <= S_DONE;
                            r_edge  <= 1'b1;
                            r_early <= 1'b1;
                        end else if ({1'b0, thresh} > C_LEN) begin
                            r_state <= S_DONE;
                            r_early <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_ones   <= w_cnt_next;
                    r_cycles <= w_e;
                    if (w_hit) begin
                        r_state <= S_DONE;
                        r_edge  <= 1'b1;
                        r_early <= w_early;
                    end else if (w_miss) begin
                        r_state <= S_DONE;
                        r_edge  <= 1'b0;
                        r_early <= w_early;
                    end else begin
                        r_cnt <= r_cnt + WIDTH'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rced_et_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rced_et_ctrl
// Description : Scoreboard bench for rced_et_ctrl with a behavioural RCED.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rced_et_ctrl;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic       e;
        logic [8:0] ones;
        logic [8:0] cyc;
        logic       early;
    } res_t;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0][WIDTH-1:0] Bxs;
    logic [WIDTH:0]        thresh;
    logic [3:0]            x;
    logic                  c;
    logic                  z;
    logic                  out_valid;
    logic                  out_ready;
    logic                  edge_det;
    logic [WIDTH:0]        ones_cnt;
    logic [WIDTH:0]        cycles;
    logic                  early;

    res_t exp_q[$];
    res_t mon_exp;
    int   n_checks = 0;
    int   n_fail   = 0;

    rced_et_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Bxs       (Bxs),
        .thresh    (thresh),
        .x         (x),
        .c         (c),
        .z         (z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .edge_det  (edge_det),
        .ones_cnt  (ones_cnt),
        .cycles    (cycles),
        .early     (early)
    );

    // Stochastic Roberts cross: c selects which diagonal pair is XOR-compared.
    assign z = c ? (x[0] ^ x[3]) : (x[1] ^ x[2]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every completed result handshake is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("edge", int'(edge_det), int'(mon_exp.e));
                    chk("ones_cnt", int'(ones_cnt), int'(mon_exp.ones));
                    chk("cycles", int'(cycles), int'(mon_exp.cyc));
                    chk("early", int'(early), int'(mon_exp.early));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Offer one job, check the first post-accept cycle, wait (bounded) for DONE.
    task automatic run_job(input logic [31:0] bxs, input int th, input res_t exp,
                           input logic [3:0] first_x);
        int n;
        @(negedge clk);
        chk("in_ready_idle", int'(in_ready), 1);
        in_valid = 1'b1;
        Bxs      = bxs;
        thresh   = th[WIDTH:0];
        exp_q.push_back(exp);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("x_first", int'(x), int'(first_x));
        n = 0;
        while (!out_valid && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", int'(out_valid), 1);
        chk("x_done", int'(x), 0);
        chk("c_done", int'(c), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        Bxs       = '0;
        thresh    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_c", int'(c), 0);
        chk("rst_ones", int'(ones_cnt), 0);
        chk("rst_cycles", int'(cycles), 0);
        chk("rst_edge", int'(edge_det), 0);
        chk("rst_early", int'(early), 0);

        // Directed jobs: {Bx3,Bx2,Bx1,Bx0}, thresh, {edge, ones, cycles, early}, first x.
        run_job(32'h64646464, 1,   '{1'b0, 9'd0,  9'd256, 1'b0}, 4'b1111);
        run_job(32'h000000FF, 10,  '{1'b1, 9'd10, 9'd20,  1'b1}, 4'b0001);
        run_job(32'h000000FF, 200, '{1'b0, 9'd56, 9'd113, 1'b1}, 4'b0001);
        run_job(32'h64646464, 0,   '{1'b1, 9'd0,  9'd0,   1'b1}, 4'b0000);
        run_job(32'h64646464, 300, '{1'b0, 9'd0,  9'd0,   1'b1}, 4'b0000);
        run_job(32'hFFFFFFFF, 257, '{1'b0, 9'd0,  9'd0,   1'b1}, 4'b0000);
        run_job(32'h00000000, 256, '{1'b0, 9'd0,  9'd1,   1'b1}, 4'b0000);
        run_job(32'h00008000, 64,  '{1'b1, 9'd64, 9'd127, 1'b1}, 4'b0010);
        run_job(32'h000000FF, 1,   '{1'b1, 9'd1,  9'd2,   1'b1}, 4'b0001);

        // Back-pressure in DONE with a competing job offered.
        @(posedge clk);
        #1 out_ready = 1'b0;
        run_job(32'h000000FF, 10, '{1'b1, 9'd10, 9'd20, 1'b1}, 4'b0001);
        repeat (5) begin
            @(posedge clk);
            #1 in_valid = 1'b1;
            Bxs    = 32'h64646464;
            thresh = 9'd0;
            @(negedge clk);
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_edge", int'(edge_det), 1);
            chk("hold_ones", int'(ones_cnt), 10);
            chk("hold_cycles", int'(cycles), 20);
            chk("hold_early", int'(early), 1);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_in_ready", int'(in_ready), 1);
        chk("release_out_valid", int'(out_valid), 0);
        chk("release_x", int'(x), 0);

        // Reset at cycle 50 of a RUN; the aborted job must not report.
        @(negedge clk);
        in_valid = 1'b1;
        Bxs      = 32'h64646464;
        thresh   = 9'd1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk("run50_x", int'(x), 15);
        chk("run50_cycles", int'(cycles), 50);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_x", int'(x), 0);
        chk("abort_c", int'(c), 0);
        chk("abort_cycles", int'(cycles), 0);

        run_job(32'h000000FF, 10, '{1'b1, 9'd10, 9'd20, 1'b1}, 4'b0001);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rced_et_ctrl.md
RCED_ET_CTRL -- requirements
Module: rced_et_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the pixel width; the full stream length SHALL be L = 2^WIDTH cycles.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset; it SHALL be synchronous and active-low.
REQ-004 in_valid  input  1  a job (Bxs, thresh) is offered.
REQ-005 in_ready  output  1  the controller can accept a job.
REQ-006 Bxs  input  4 x WIDTH  binary pixel values for RCED inputs x[0..3].
REQ-007 thresh  input  WIDTH+1  edge threshold on the count of z ones.
REQ-008 x  output  4  stochastic bits driven to the external RCED datapath.
REQ-009 c  output  1  RCED select bit.
REQ-010 z  input  1  RCED output; combinational from the same-cycle x and c.
REQ-011 out_valid  output  1  the result fields are valid.
REQ-012 out_ready  input  1  the consumer accepts the result.
REQ-013 edge  output  1  1 = threshold reached; 0 = threshold unreachable.
REQ-014 ones_cnt  output  WIDTH+1  number of z=1 cycles counted.
REQ-015 cycles  output  WIDTH+1  number of RUN cycles executed.
REQ-016 early  output  1  1 when cycles < L.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-018 in_ready SHALL equal (state==IDLE), and a job SHALL be accepted only on in_valid & in_ready.
REQ-019 On acceptance, the controller SHALL latch Bxs and thresh, and clear ones_cnt, cycles and the SNG counter r.
REQ-020 On acceptance with thresh==0, the next state SHALL be DONE with edge=1, ones_cnt=0 and cycles=0.
REQ-021 On acceptance with thresh>L, the next state SHALL be DONE with edge=0, ones_cnt=0 and cycles=0.
REQ-022 On any other acceptance, the next state SHALL be RUN with r=0.
REQ-023 In RUN, the SNG SHALL be a WIDTH-bit up-counter r, with x[i] = (r < Bx_i) for every i; all four streams SHALL share r (correlated).
REQ-024 In RUN, c SHALL equal r[0].
REQ-025 Outside RUN, x and c SHALL be 0.
REQ-026 In each RUN cycle, the controller SHALL form cnt' = ones_cnt + z and e = cycles + 1, then register both values.
REQ-027 In a RUN cycle where cnt' >= thresh, the next state SHALL be DONE with edge=1.
REQ-028 Otherwise, in a RUN cycle where cnt' + (L - e) < thresh, the next state SHALL be DONE with edge=0; this condition also covers e==L.
REQ-029 In a RUN cycle where neither termination condition holds, r SHALL increment by 1 and the state SHALL stay RUN; r SHALL never wrap inside a job.
REQ-030 out_valid SHALL equal (state==DONE), and edge, ones_cnt, cycles and early SHALL hold stable while out_valid=1.
REQ-031 The controller SHALL leave DONE for IDLE on out_ready; out_valid SHALL be 1 for at least one cycle, and the earliest new acceptance SHALL be the cycle after the return to IDLE.
REQ-032 The latency from termination to out_valid SHALL be one cycle, and the latency from acceptance to the first RUN cycle SHALL be one cycle.
REQ-033 in_valid SHALL be ignored outside IDLE, and latched job data SHALL not change outside IDLE.

Reset
REQ-034 On rst_n=0 at a clock edge, the state SHALL become IDLE, r and all counters SHALL become 0, and out_valid, edge, early, x and c SHALL be 0; in_ready SHALL be 1 in the following cycle.
REQ-035 Reset SHALL take priority over all other events, including mid-RUN and mid-DONE; an aborted job SHALL produce no result.

Verification
REQ-036 With WIDTH=8, Bxs={100,100,100,100} and thresh=1: the job SHALL run the full stream and end with edge=0, ones_cnt=0, cycles=256, early=0.
REQ-037 With Bx0=255, Bx3=0, Bx1=Bx2=0 and thresh=10: ones SHALL occur on odd r, and the job SHALL end with edge=1, ones_cnt=10, cycles=20, early=1.
REQ-038 With the same Bxs and thresh=200: the job SHALL end with edge=0, ones_cnt=56, cycles=113, early=1.
REQ-039 With thresh=0, then separately thresh=300: out_valid SHALL assert in the cycle after acceptance, with edge=1 and edge=0 respectively, cycles=0, and x=0 throughout.
REQ-040 With out_ready held at 0 for 5 cycles in DONE: the outputs SHALL stay stable, in_ready SHALL stay 0, and in_valid SHALL be ignored; then out_ready=1 -> the state SHALL return to IDLE.
REQ-041 With rst_n=0 for one cycle at cycle 50 of a RUN: the next cycle SHALL show IDLE with out_valid=0, x=0, c=0 and in_ready=1, and a new job SHALL then complete correctly.
